prior_scanner: RTL and testbench
================================

// Module: prior_scanner
// PURPOSE
//  Parametrised successor to the 8-bit combinational priority decoder.
//  Accepts a WIDTH-bit request vector over a valid/ready handshake, then emits the
//  index of every set bit, highest first, one index per beat on a valid/ready output.
//  Used wherever a set of flags must be serviced one at a time in strict priority order.
// PARAMETERS
//  WIDTH   8               request vector width; >=2, need not be a power of two
//  IDX_W   $clog2(WIDTH)   localparam; output index width
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      in_vec is valid
//  in_ready   out  1      block can capture a new vector
//  in_vec     in   WIDTH  request vector; bit WIDTH-1 has highest priority
//  out_valid  out  1      out_idx/out_last/out_empty are valid
//  out_ready  in   1      consumer accepts the current beat
//  out_idx    out  IDX_W  index of highest set bit still pending
//  out_last   out  1      current beat is the final beat for this vector
//  out_empty  out  1      captured vector was all-zero (single beat, out_idx=0)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, work register=0, empty flag=0.
//    Outputs: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_empty=0.
//  - FSM, two states:
//    - IDLE: in_ready=1, out_valid=0.
//      On in_valid&&in_ready: work<=in_vec (masked, see CONFIGURATION);
//      empty<=(vector==0); go to EMIT.
//    - EMIT: in_ready=0, out_valid=1.
//      out_idx = highest set bit of work (0 if empty); out_last = (work has <=1 bit set).
//      On out_valid&&out_ready: clear bit out_idx in work. If out_last, go to IDLE.
//  - Latency: first beat is valid the cycle after capture. Throughput is one index per
//    cycle while out_ready=1. A vector with k set bits takes k beats (min 1).
//  - All outputs are driven from registered state only; no in_* to out_* combinational path.
//  - Stall (out_ready=0): out_idx/out_last/out_empty hold stable while out_valid=1.
//  - in_ready is 0 for the whole of EMIT, including the last-beat accept cycle.
//    A new vector is captured no earlier than the cycle after returning to IDLE.
//  - in_vec is ignored whenever in_ready=0.
//  - Reset mid-EMIT: pending bits are discarded immediately; no partial beats after reset.
//  - Non-power-of-two WIDTH: out_idx never exceeds WIDTH-1.
// CONFIGURATION
//  PRIOR_SCANNER_MASK_EN defined:
//    - Adds port in_mask (in, WIDTH); captured vector = in_vec & in_mask.
//    - out_empty reflects the masked vector.
//  PRIOR_SCANNER_MASK_EN undefined:
//    - No in_mask port; captured vector = in_vec.
// STRUCTURE
//  - Package prior_pkg: state encoding constants (ST_IDLE=1'b0, ST_EMIT=1'b1) and a
//    clog2 function for IDX_W.
//  - Sub-module prior_encoder_comb #(WIDTH): combinational highest-set-bit finder
//    producing idx, any, and multi (>1 bit set). Instantiated once on the work register.
//  - Top: FSM, work register, bit-clear logic, handshake.
// TESTING
//  - Reset, then capture in_vec=8'b1010_0110 with out_ready=1 -> beats idx 7,5,2,1;
//    out_last=1 only on idx 1; in_ready returns 1 one cycle later.
//  - in_vec=8'h00 -> single beat: out_empty=1, out_idx=0, out_last=1.
//  - in_vec=8'h80 with out_ready held 0 for 5 cycles -> out_idx=7, out_last=1 held
//    stable; accepted on the first cycle out_ready=1.
//  - Assert rst_n=0 mid-EMIT after 1 of 3 beats -> out_valid=0 and in_ready=1
//    asynchronously; no further beats.
//  - WIDTH=13, in_vec=13'h1001 -> beats 12, 0; in_vec=13'h1FFF -> 13 beats, 12..0.
//  - MASK_EN: in_vec=8'hFF, in_mask=8'h0F -> beats 3,2,1,0;
//    in_mask=8'h00 -> out_empty=1.

Source files
------------

// File: rtl/prior_pkg.sv
// Shared constants for the priority scanner: FSM state encoding and a clog2 helper
// used to size index ports.
package prior_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result++;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prior_encoder_comb.sv
// Combinational highest-set-bit finder: reports the top index, whether any bit is set,
// and whether more than one bit is set.
module prior_encoder_comb
  import prior_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any,
  output logic             o_multi
);

  // Ascending scan: the last set bit seen wins, and meeting a set bit after one
  // was already found means at least two are set.
  always_comb begin
    o_idx   = '0;
    o_any   = 1'b0;
    o_multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_vec[i]) begin
        if (o_any) o_multi = 1'b1;
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prior_scanner.sv
// Captures a request vector and emits the index of each set bit, highest first, one per beat.
// Optional PRIOR_SCANNER_MASK_EN adds an in_mask port ANDed into the captured vector.
module prior_scanner
  import prior_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
`ifdef PRIOR_SCANNER_MASK_EN
  input  logic [WIDTH-1:0] in_mask,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty
);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic             r_empty;

  logic [WIDTH-1:0] w_captured;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;
  logic             w_emit;

`ifdef PRIOR_SCANNER_MASK_EN
  assign w_captured = in_vec & in_mask;
`else
  assign w_captured = in_vec;
`endif

  prior_encoder_comb #(.WIDTH(WIDTH)) u_encoder (
    .i_vec   (r_work),
    .o_idx   (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  // Outputs come only from registered state; the work register is zero whenever idle.
  assign w_emit    = (r_state == ST_EMIT);
  assign in_ready  = ~w_emit;
  assign out_valid = w_emit;
  assign out_idx   = w_idx;
  assign out_last  = w_emit & ~w_multi;
  assign out_empty = w_emit & r_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_empty <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_work  <= w_captured;
            r_empty <= (w_captured == '0);
            r_state <= ST_EMIT;
          end
        end
        default: begin
          if (out_ready) begin
            if (w_any) r_work <= r_work & ~(WIDTH'(1) << w_idx);
            if (!w_multi) r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prior_scanner.sv
// Self-checking bench for prior_scanner: an 8-bit and a 13-bit instance checked every
// cycle against a queue-of-beats model, plus hand-computed literal expectations.
module tb_prior_scanner;

  typedef struct {
    int idx;
    bit last;
    bit empty;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic       inValidA = 1'b0;
  logic       inReadyA;
  logic [7:0] inVecA = '0;
  logic       outValidA;
  logic       outReadyA = 1'b1;
  logic [2:0] outIdxA;
  logic       outLastA;
  logic       outEmptyA;
`ifdef PRIOR_SCANNER_MASK_EN
  logic [7:0] inMaskA = 8'hFF;
`endif

  logic        inValidB = 1'b0;
  logic        inReadyB;
  logic [12:0] inVecB = '0;
  logic        outValidB;
  logic        outReadyB = 1'b1;
  logic [3:0]  outIdxB;
  logic        outLastB;
  logic        outEmptyB;

  int checks = 0;
  int failures = 0;
  bit monEn = 1'b0;

  beat_t qA[$];
  beat_t qB[$];
  bit busyA = 1'b0;
  bit busyB = 1'b0;

  always #5 clk = ~clk;

  prior_scanner #(.WIDTH(8)) dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValidA),
    .in_ready  (inReadyA),
    .in_vec    (inVecA),
`ifdef PRIOR_SCANNER_MASK_EN
    .in_mask   (inMaskA),
`endif
    .out_valid (outValidA),
    .out_ready (outReadyA),
    .out_idx   (outIdxA),
    .out_last  (outLastA),
    .out_empty (outEmptyA)
  );

  prior_scanner #(.WIDTH(13)) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValidB),
    .in_ready  (inReadyB),
    .in_vec    (inVecB),
`ifdef PRIOR_SCANNER_MASK_EN
    .in_mask   (13'h1FFF),
`endif
    .out_valid (outValidB),
    .out_ready (outReadyB),
    .out_idx   (outIdxB),
    .out_last  (outLastB),
    .out_empty (outEmptyB)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // The beat list a vector should produce: each set bit from the top down, or one empty beat.
  function automatic void buildBeats(input int width, input logic [15:0] vec, output beat_t q[$]);
    q = {};
    for (int i = width - 1; i >= 0; i--)
      if (vec[i]) q.push_back('{idx: i, last: 1'b0, empty: 1'b0});
    if (q.size() == 0) q.push_back('{idx: 0, last: 1'b1, empty: 1'b1});
    else q[q.size()-1].last = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyA = 1'b0;
      qA = {};
    end else if (!busyA && inValidA) begin
`ifdef PRIOR_SCANNER_MASK_EN
      buildBeats(8, {8'h00, inVecA & inMaskA}, qA);
`else
      buildBeats(8, {8'h00, inVecA}, qA);
`endif
      busyA = 1'b1;
    end else if (busyA && outReadyA) begin
      void'(qA.pop_front());
      if (qA.size() == 0) busyA = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyB = 1'b0;
      qB = {};
    end else if (!busyB && inValidB) begin
      buildBeats(13, {3'b000, inVecB}, qB);
      busyB = 1'b1;
    end else if (busyB && outReadyB) begin
      void'(qB.pop_front());
      if (qB.size() == 0) busyB = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("A.in_ready", int'(inReadyA), int'(!busyA));
      checkOutput("A.out_valid", int'(outValidA), int'(busyA));
      checkOutput("A.out_idx", int'(outIdxA), busyA ? qA[0].idx : 0);
      checkOutput("A.out_last", int'(outLastA), busyA ? int'(qA[0].last) : 0);
      checkOutput("A.out_empty", int'(outEmptyA), busyA ? int'(qA[0].empty) : 0);
      checkOutput("B.in_ready", int'(inReadyB), int'(!busyB));
      checkOutput("B.out_valid", int'(outValidB), int'(busyB));
      checkOutput("B.out_idx", int'(outIdxB), busyB ? qB[0].idx : 0);
      checkOutput("B.out_last", int'(outLastB), busyB ? int'(qB[0].last) : 0);
      checkOutput("B.out_empty", int'(outEmptyB), busyB ? int'(qB[0].empty) : 0);
    end
  end

  // Presents one vector for one cycle and returns on the negedge after capture.
  task automatic applyStimulus(input bit selB, input logic [15:0] vec, input bit ready);
    @(negedge clk);
    if (selB) begin
      inVecB = vec[12:0];
      inValidB = 1'b1;
      outReadyB = ready;
    end else begin
      inVecA = vec[7:0];
      inValidA = 1'b1;
      outReadyA = ready;
    end
    @(negedge clk);
    inValidA = 1'b0;
    inValidB = 1'b0;
  endtask

  task automatic waitIdle(input bit selB, input int bound);
    int n;
    n = 0;
    while ((selB ? busyB : busyA) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (selB ? busyB : busyA) checkOutput("idle timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 monEn = 1'b1;
    checkOutput("reset in_ready", int'(inReadyA), 1);
    checkOutput("reset out_valid", int'(outValidA), 0);
    checkOutput("reset out_last", int'(outLastA), 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 16'h00A6, 1'b1);
    checkOutput("A6 beat0 idx", int'(outIdxA), 7);
    @(negedge clk);
    checkOutput("A6 beat1 idx", int'(outIdxA), 5);
    waitIdle(1'b0, 20);
    checkOutput("A6 in_ready back", int'(inReadyA), 1);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("empty out_empty", int'(outEmptyA), 1);
    checkOutput("empty out_last", int'(outLastA), 1);
    checkOutput("empty out_idx", int'(outIdxA), 0);
    waitIdle(1'b0, 20);

    applyStimulus(1'b0, 16'h0080, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall idx", int'(outIdxA), 7);
      checkOutput("stall last", int'(outLastA), 1);
      if (i < 4) @(negedge clk);
    end
    outReadyA = 1'b1;
    @(negedge clk);
    checkOutput("stall accepted", int'(outValidA), 0);

    applyStimulus(1'b0, 16'h0015, 1'b1);
    checkOutput("rst beat0 idx", int'(outIdxA), 4);
    @(negedge clk);
    checkOutput("rst beat1 idx", int'(outIdxA), 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", int'(outValidA), 0);
    checkOutput("async rst in_ready", int'(inReadyA), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post rst out_valid", int'(outValidA), 0);

    applyStimulus(1'b1, 16'h1001, 1'b1);
    checkOutput("B 1001 beat0", int'(outIdxB), 12);
    @(negedge clk);
    checkOutput("B 1001 beat1", int'(outIdxB), 0);
    checkOutput("B 1001 last", int'(outLastB), 1);
    waitIdle(1'b1, 20);

    applyStimulus(1'b1, 16'h1FFF, 1'b1);
    checkOutput("B 1FFF beat0", int'(outIdxB), 12);
    waitIdle(1'b1, 40);

`ifdef PRIOR_SCANNER_MASK_EN
    inMaskA = 8'h0F;
    applyStimulus(1'b0, 16'h00FF, 1'b1);
    checkOutput("mask beat0 idx", int'(outIdxA), 3);
    waitIdle(1'b0, 20);
    inMaskA = 8'h00;
    applyStimulus(1'b0, 16'h00FF, 1'b1);
    checkOutput("mask empty", int'(outEmptyA), 1);
    waitIdle(1'b0, 20);
    inMaskA = 8'hFF;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
